// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
// Bundles the instruction-memory port, the pipeline control inputs and the
// IF/ID outputs of the fetch stage.
//   master : the fetch unit (drives o_*, receives i_*)
//   slave  : the surrounding pipeline / memory (drives i_*, receives o_*)
// Signals:
//   i_mem_data         16  memory read data (one cycle after address/enable)
//   i_stall             1  freeze the fetch stage
//   i_redirect_valid    1  load a new PC
//   i_redirect_address 32  redirect target word address
//   o_mem_address      32  memory word address
//   o_mem_enable        1  memory read enable
//   o_instruction      16  first instruction word
//   o_immediate        16  second (immediate) word, zero for one-word ops
//   o_pc               32  address of o_instruction
//   o_valid             1  outputs hold a real instruction
// ---------------------------------------------------------------------------
interface fetch_unit_if;
  logic [15:0] i_mem_data;
  logic        i_stall;
  logic        i_redirect_valid;
  logic [31:0] i_redirect_address;
  logic [31:0] o_mem_address;
  logic        o_mem_enable;
  logic [15:0] o_instruction;
  logic [15:0] o_immediate;
  logic [31:0] o_pc;
  logic        o_valid;

  modport master (
    input  i_mem_data, i_stall, i_redirect_valid, i_redirect_address,
    output o_mem_address, o_mem_enable, o_instruction, o_immediate, o_pc, o_valid
  );

  modport slave (
    output i_mem_data, i_stall, i_redirect_valid, i_redirect_address,
    input  o_mem_address, o_mem_enable, o_instruction, o_immediate, o_pc, o_valid
  );
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage in front of a synchronous 16-bit instruction
// memory. Owns the PC, issues one memory read per unstalled cycle and
// assembles one- or two-word instructions for the IF/ID boundary.
// Ports:
//   i_clk    clock, rising edge
//   i_reset  asynchronous active-high reset
//   bus      fetch_unit_if.master (memory port, stall/redirect, IF/ID outputs)
// Parameters:
//   RESET_VECTOR  PC loaded on reset
//   IMM_FLAG_BIT  bit of the first word that announces an immediate word
// Optional feature (macro BOOT_VECTOR_FETCH_EN):
//   when defined, reset runs a three-cycle boot sequence that reads the start
//   PC from memory words 0 (high half) and 1 (low half) before fetching.
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned IMM_FLAG_BIT = 32'd0
) (
  input logic          i_clk,
  input logic          i_reset,
  fetch_unit_if.master bus
);

  typedef enum logic {
    ASM_FIRST  = 1'b0,
    ASM_SECOND = 1'b1
  } asm_state_t;

`ifdef BOOT_VECTOR_FETCH_EN
  typedef enum logic [1:0] {
    BOOT_A = 2'd0,
    BOOT_B = 2'd1,
    BOOT_C = 2'd2,
    RUN    = 2'd3
  } boot_state_t;

  boot_state_t boot_state_r;
  boot_state_t boot_state_s;
`endif

  logic [31:0] pc_r,        pc_s;
  logic        pend_v_r,    pend_v_s;     // a memory word returns this cycle
  logic [31:0] pend_addr_r, pend_addr_s;  // address of that returning word
  asm_state_t  asm_state_r, asm_state_s;
  logic [15:0] hold_word_r, hold_word_s;  // first word of a two-word op
  logic [31:0] hold_addr_r, hold_addr_s;
  logic [15:0] instr_r,     instr_s;
  logic [15:0] imm_r,       imm_s;
  logic [31:0] out_pc_r,    out_pc_s;
  logic        valid_r,     valid_s;

  logic        run_s;
  logic        imm_flag_s;
  logic [31:0] mem_addr_s;
  logic        mem_en_s;

`ifdef BOOT_VECTOR_FETCH_EN
  assign run_s = (boot_state_r == RUN);
`else
  assign run_s = 1'b1;
`endif

  assign imm_flag_s = bus.i_mem_data[IMM_FLAG_BIT];

  // Next-state and memory-port logic: boot sequencing, then redirect > stall > fetch.
  always_comb begin
    pc_s        = pc_r;
    pend_v_s    = pend_v_r;
    pend_addr_s = pend_addr_r;
    asm_state_s = asm_state_r;
    hold_word_s = hold_word_r;
    hold_addr_s = hold_addr_r;
    instr_s     = instr_r;
    imm_s       = imm_r;
    out_pc_s    = out_pc_r;
    valid_s     = valid_r;
    mem_addr_s  = pc_r;
    mem_en_s    = 1'b0;

`ifdef BOOT_VECTOR_FETCH_EN
    boot_state_s = boot_state_r;
    case (boot_state_r)
      BOOT_A: begin
        mem_addr_s   = 32'h0000_0000;
        mem_en_s     = 1'b1;
        boot_state_s = BOOT_B;
      end
      BOOT_B: begin
        // data for word 0 arrives now: high half of the start PC
        mem_addr_s   = 32'h0000_0001;
        mem_en_s     = 1'b1;
        pc_s         = {bus.i_mem_data, pc_r[15:0]};
        boot_state_s = BOOT_C;
      end
      BOOT_C: begin
        pc_s         = {pc_r[31:16], bus.i_mem_data};
        boot_state_s = RUN;
      end
      RUN: begin
        boot_state_s = RUN;
      end
      default: begin
        boot_state_s = BOOT_A;
      end
    endcase
`endif

    if (run_s) begin
      mem_en_s = !bus.i_stall && !bus.i_redirect_valid;
      if (bus.i_redirect_valid) begin
        // drop the in-flight word and any half-built instruction
        pc_s        = bus.i_redirect_address;
        pend_v_s    = 1'b0;
        asm_state_s = ASM_FIRST;
        valid_s     = 1'b0;
      end else if (bus.i_stall) begin
        // memory is not enabled, so i_mem_data keeps the in-flight word
        pc_s = pc_r;
      end else begin
        pc_s        = pc_r + 32'd1;
        pend_v_s    = 1'b1;
        pend_addr_s = pc_r;
        if (!pend_v_r) begin
          valid_s = 1'b0;
        end else if (asm_state_r == ASM_SECOND) begin
          // immediate word: its flag bit carries no meaning
          instr_s     = hold_word_r;
          imm_s       = bus.i_mem_data;
          out_pc_s    = hold_addr_r;
          valid_s     = 1'b1;
          asm_state_s = ASM_FIRST;
        end else if (imm_flag_s) begin
          hold_word_s = bus.i_mem_data;
          hold_addr_s = pend_addr_r;
          asm_state_s = ASM_SECOND;
          valid_s     = 1'b0;
        end else begin
          instr_s  = bus.i_mem_data;
          imm_s    = 16'h0000;
          out_pc_s = pend_addr_r;
          valid_s  = 1'b1;
        end
      end
    end else begin
      mem_en_s = mem_en_s;
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pc_r        <= RESET_VECTOR;
      pend_v_r    <= 1'b0;
      pend_addr_r <= 32'h0000_0000;
      asm_state_r <= ASM_FIRST;
      hold_word_r <= 16'h0000;
      hold_addr_r <= 32'h0000_0000;
      instr_r     <= 16'h0000;
      imm_r       <= 16'h0000;
      out_pc_r    <= 32'h0000_0000;
      valid_r     <= 1'b0;
`ifdef BOOT_VECTOR_FETCH_EN
      boot_state_r <= BOOT_A;
`endif
    end else begin
      pc_r        <= pc_s;
      pend_v_r    <= pend_v_s;
      pend_addr_r <= pend_addr_s;
      asm_state_r <= asm_state_s;
      hold_word_r <= hold_word_s;
      hold_addr_r <= hold_addr_s;
      instr_r     <= instr_s;
      imm_r       <= imm_s;
      out_pc_r    <= out_pc_s;
      valid_r     <= valid_s;
`ifdef BOOT_VECTOR_FETCH_EN
      boot_state_r <= boot_state_s;
`endif
    end
  end

  assign bus.o_mem_address = mem_addr_s;
  assign bus.o_mem_enable  = mem_en_s;
  assign bus.o_instruction = instr_r;
  assign bus.o_immediate   = imm_r;
  assign bus.o_pc          = out_pc_r;
  assign bus.o_valid       = valid_r;

endmodule
